// File: rtl/display_mux_n.sv
// Time-multiplexed common-anode driver for up to 8 hex digits, with a double-buffered
// load, per-digit blink, leading-zero suppression and 16-level PWM brightness.
module display_mux_n #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIV_BITS     = 11,
   parameter int BLINK_FRAMES = 128
) (
   input  logic                    clk5,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] dispVal,
   input  logic [NUM_DIGITS-1:0]   point,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic                    lzs_en,
   input  logic [3:0]              brightness,
   output logic                    busy,
   output logic [7:0]              digit,
   output logic [7:0]              segment
);

   localparam int             BC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [2:0]     IDX_LAST = 3'(NUM_DIGITS - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

   logic [DIV_BITS-1:0]     div_q, div_d;
   logic [2:0]              idx_q, idx_d;
   logic [BC_W-1:0]         bcnt_q, bcnt_d;
   logic                    phase_q, phase_d;
   logic                    busy_q, busy_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, sh_val_q, sh_val_d;
   logic [NUM_DIGITS-1:0]   pend_pt_q, pend_pt_d, sh_pt_q, sh_pt_d;
   logic [NUM_DIGITS-1:0]   pend_bl_q, pend_bl_d, sh_bl_q, sh_bl_d;
   logic [7:0]              digit_q, digit_d, seg_q, seg_d;

   logic                    tick, frame_end;

   function automatic logic [6:0] font(input logic [3:0] h);
      case (h)
         4'h0: font = 7'h01;  4'h1: font = 7'h4F;  4'h2: font = 7'h12;  4'h3: font = 7'h06;
         4'h4: font = 7'h4C;  4'h5: font = 7'h24;  4'h6: font = 7'h20;  4'h7: font = 7'h0F;
         4'h8: font = 7'h00;  4'h9: font = 7'h04;  4'hA: font = 7'h08;  4'hB: font = 7'h60;
         4'hC: font = 7'h31;  4'hD: font = 7'h42;  4'hE: font = 7'h30;  default: font = 7'h38;
      endcase
   endfunction

   always_comb begin
      div_d      = div_q + DIV_BITS'(1);
      tick       = &div_q;
      frame_end  = tick && (idx_q == IDX_LAST);
      idx_d      = idx_q;
      bcnt_d     = bcnt_q;
      phase_d    = phase_q;
      busy_d     = busy_q;
      pend_val_d = pend_val_q;
      pend_pt_d  = pend_pt_q;
      pend_bl_d  = pend_bl_q;
      sh_val_d   = sh_val_q;
      sh_pt_d    = sh_pt_q;
      sh_bl_d    = sh_bl_q;

      if (tick) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;

      if (frame_end) begin
         if (bcnt_q == BC_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BC_W'(1);
         end
      end

      // The shadow only ever changes on a frame boundary, so a frame is never torn.
      if (load && frame_end) begin
         sh_val_d = dispVal;
         sh_pt_d  = point;
         sh_bl_d  = blink;
         busy_d   = 1'b0;
      end else if (frame_end && busy_q) begin
         sh_val_d = pend_val_q;
         sh_pt_d  = pend_pt_q;
         sh_bl_d  = pend_bl_q;
         busy_d   = 1'b0;
      end else if (load) begin
         pend_val_d = dispVal;
         pend_pt_d  = point;
         pend_bl_d  = blink;
         busy_d     = 1'b1;
      end
   end

   logic [3:0]            nib;
   logic                  pt, bl, blank, off, all_zero;
   logic [NUM_DIGITS-1:0] zero_from;

   always_comb begin
      nib       = 4'd0;
      pt        = 1'b0;
      bl        = 1'b0;
      blank     = 1'b0;
      all_zero  = 1'b1;
      zero_from = '0;
      // zero_from[i]: every nibble from i up to the leftmost active digit is zero.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero     = all_zero && (sh_val_q[4*i +: 4] == 4'd0);
         zero_from[i] = all_zero;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            nib   = sh_val_q[4*i +: 4];
            pt    = sh_pt_q[i];
            bl    = sh_bl_q[i];
            blank = lzs_en && (i != 0) && zero_from[i];
         end
      end
      off     = (bl && phase_q) || (div_q[DIV_BITS-1 -: 4] > brightness);
      digit_d = 8'hFF;
      if (!off) digit_d[idx_q] = 1'b0;
      seg_d   = {blank ? 7'h7F : font(nib), ~pt};
   end

   always_ff @(posedge clk5) begin
      if (reset) begin
         div_q      <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         phase_q    <= 1'b0;
         busy_q     <= 1'b0;
         pend_val_q <= '0;
         pend_pt_q  <= '0;
         pend_bl_q  <= '0;
         sh_val_q   <= '0;
         sh_pt_q    <= '0;
         sh_bl_q    <= '0;
         digit_q    <= 8'hFF;
         seg_q      <= 8'hFF;
      end else begin
         div_q      <= div_d;
         idx_q      <= idx_d;
         bcnt_q     <= bcnt_d;
         phase_q    <= phase_d;
         busy_q     <= busy_d;
         pend_val_q <= pend_val_d;
         pend_pt_q  <= pend_pt_d;
         pend_bl_q  <= pend_bl_d;
         sh_val_q   <= sh_val_d;
         sh_pt_q    <= sh_pt_d;
         sh_bl_q    <= sh_bl_d;
         digit_q    <= digit_d;
         seg_q      <= seg_d;
      end
   end

   assign busy    = busy_q;
   assign digit   = digit_q;
   assign segment = seg_q;

endmodule

// File: tb/tb_display_mux_n.sv
// Directed bench for display_mux_n with NUM_DIGITS=4, DIV_BITS=4, BLINK_FRAMES=2.
module tb_display_mux_n;

   logic        clk5 = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] dispVal;
   logic [3:0]  point;
   logic [3:0]  blink;
   logic        lzs_en;
   logic [3:0]  brightness;
   logic        busy;
   logic [7:0]  digit;
   logic [7:0]  segment;

   int total = 0;
   int bad   = 0;

   display_mux_n #(.NUM_DIGITS(4), .DIV_BITS(4), .BLINK_FRAMES(2)) dut (
      .clk5(clk5), .reset(reset), .load(load), .dispVal(dispVal), .point(point),
      .blink(blink), .lzs_en(lzs_en), .brightness(brightness), .busy(busy),
      .digit(digit), .segment(segment)
   );

   always #5 clk5 = ~clk5;

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation did not finish");
   end

   // Waits for the digit output to newly become tgt; a missed window counts as a failure.
   task automatic wait_edge(input logic [7:0] tgt);
      logic [7:0] prev;
      bit found;
      prev  = digit;
      found = 1'b0;
      for (int n = 0; n < 300 && !found; n++) begin
         @(negedge clk5);
         if (digit == tgt && prev != tgt) found = 1'b1;
         prev = digit;
      end
      if (!found) begin
         total++; bad++;
         $display("FAIL wait_digit_%h timeout got=%h", tgt, digit);
      end
   endtask

   task automatic load_val(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
      dispVal = v; point = p; blink = b; load = 1'b1;
      @(negedge clk5);
      load = 1'b0;
   endtask

   task automatic apply(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
      wait_edge(8'hFD);
      load_val(v, p, b);
      for (int n = 0; n < 200 && busy; n++) @(negedge clk5);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL apply_busy_clear got=%b want=0", busy); end
   endtask

   task automatic test_reset;
      logic [7:0] scan [4];
      scan = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      total++;
      if (digit !== 8'hFF) begin bad++; $display("FAIL reset_digit got=%h want=ff", digit); end
      total++;
      if (segment !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", segment); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      reset = 1'b0;
      for (int k = 0; k <= 64; k++) begin
         @(negedge clk5);
         if (k % 16 == 0 || k % 16 == 15) begin
            total++;
            if (digit !== scan[(k / 16) % 4]) begin
               bad++; $display("FAIL scan_k%0d digit got=%h want=%h", k, digit, scan[(k / 16) % 4]);
            end
            total++;
            if (segment !== 8'h03) begin
               bad++; $display("FAIL scan_k%0d seg got=%h want=03", k, segment);
            end
         end
      end
   endtask

   task automatic test_load;
      int cnt;
      wait_edge(8'hFD);
      load_val(16'h12AF, 4'b0100, 4'b0000);
      cnt = 0;
      while (busy && cnt < 100) begin cnt++; @(negedge clk5); end
      total++;
      if (cnt != 46) begin bad++; $display("FAIL load_busy_cycles got=%0d want=46", cnt); end
      wait_edge(8'hFE);
      total++;
      if (segment !== 8'h71) begin bad++; $display("FAIL load_d0 seg got=%h want=71", segment); end
      wait_edge(8'hFD);
      total++;
      if (segment !== 8'h11) begin bad++; $display("FAIL load_d1 seg got=%h want=11", segment); end
      wait_edge(8'hFB);
      total++;
      if (segment !== 8'h24) begin bad++; $display("FAIL load_d2 seg got=%h want=24", segment); end
      wait_edge(8'hF7);
      total++;
      if (segment !== 8'h9F) begin bad++; $display("FAIL load_d3 seg got=%h want=9f", segment); end
   endtask

   task automatic test_back_to_back;
      int n_one, n_two;
      apply(16'h8888, 4'b0000, 4'b0000);
      wait_edge(8'hFD);
      load_val(16'h1111, 4'b0000, 4'b0000);
      load_val(16'h2222, 4'b0000, 4'b0000);
      n_one = 0; n_two = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk5);
         if (segment == 8'h9F) n_one++;
         if (segment == 8'h25) n_two++;
      end
      total++;
      if (n_one != 0) begin bad++; $display("FAIL b2b_first_shown got=%0d want=0", n_one); end
      total++;
      if (n_two < 100) begin bad++; $display("FAIL b2b_second_shown got=%0d want>=100", n_two); end
   endtask

   task automatic test_load_frame_end;
      wait_edge(8'hF7);
      repeat (14) @(negedge clk5);
      load_val(16'h0007, 4'b0000, 4'b0000);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL lfe_busy got=%b want=0", busy); end
      total++;
      if (digit !== 8'hF7) begin bad++; $display("FAIL lfe_digit3 got=%h want=f7", digit); end
      @(negedge clk5);
      total++;
      if (digit !== 8'hFE) begin bad++; $display("FAIL lfe_digit0 got=%h want=fe", digit); end
      total++;
      if (segment !== 8'h1F) begin bad++; $display("FAIL lfe_seg0 got=%h want=1f", segment); end
   endtask

   task automatic test_lzs;
      lzs_en = 1'b1;
      apply(16'h0050, 4'b1000, 4'b0000);
      wait_edge(8'hFE);
      total++;
      if (segment !== 8'h03) begin bad++; $display("FAIL lzs_d0 seg got=%h want=03", segment); end
      wait_edge(8'hFD);
      total++;
      if (segment !== 8'h49) begin bad++; $display("FAIL lzs_d1 seg got=%h want=49", segment); end
      wait_edge(8'hFB);
      total++;
      if (segment !== 8'hFF) begin bad++; $display("FAIL lzs_d2 seg got=%h want=ff", segment); end
      wait_edge(8'hF7);
      total++;
      if (segment !== 8'hFE) begin bad++; $display("FAIL lzs_d3 seg got=%h want=fe", segment); end
      lzs_en = 1'b0;
      wait_edge(8'hFB);
      total++;
      if (segment !== 8'h03) begin bad++; $display("FAIL lzs_off_d2 seg got=%h want=03", segment); end
      wait_edge(8'hF7);
      total++;
      if (segment !== 8'h02) begin bad++; $display("FAIL lzs_off_d3 seg got=%h want=02", segment); end
   endtask

   task automatic test_blink;
      bit on [8];
      int n_on;
      apply(16'h1234, 4'b0000, 4'b0001);
      wait_edge(8'hFD);
      n_on = 0;
      for (int f = 0; f < 8; f++) begin
         repeat (8) @(negedge clk5);
         total++;
         if (digit !== 8'hFD) begin bad++; $display("FAIL blink_d1_f%0d got=%h want=fd", f, digit); end
         repeat (48) @(negedge clk5);
         on[f] = (digit == 8'hFE);
         if (on[f]) n_on++;
         total++;
         if (digit !== 8'hFE && digit !== 8'hFF) begin
            bad++; $display("FAIL blink_d0_f%0d got=%h want=fe_or_ff", f, digit);
         end
         repeat (8) @(negedge clk5);
      end
      total++;
      if (n_on != 4) begin bad++; $display("FAIL blink_on_frames got=%0d want=4", n_on); end
      for (int f = 0; f < 6; f++) begin
         total++;
         if (on[f] == on[f + 2]) begin
            bad++; $display("FAIL blink_period_f%0d got=%b,%b want=differ", f, on[f], on[f + 2]);
         end
      end
   endtask

   task automatic test_brightness;
      int n_lit;
      brightness = 4'd3;
      apply(16'h1234, 4'b0000, 4'b0000);
      wait_edge(8'hFD);
      n_lit = 0;
      for (int k = 0; k < 16; k++) begin
         if (digit == 8'hFD) n_lit++;
         if (k == 4) begin
            total++;
            if (digit !== 8'hFF) begin bad++; $display("FAIL pwm_off_k4 got=%h want=ff", digit); end
         end
         if (k < 15) @(negedge clk5);
      end
      total++;
      if (n_lit != 4) begin bad++; $display("FAIL pwm_d1_lit got=%0d want=4", n_lit); end
      wait_edge(8'hF7);
      n_lit = 0;
      for (int k = 0; k < 16; k++) begin
         if (digit == 8'hF7) n_lit++;
         if (k < 15) @(negedge clk5);
      end
      total++;
      if (n_lit != 4) begin bad++; $display("FAIL pwm_d3_lit got=%0d want=4", n_lit); end
   endtask

   task automatic test_reset_mid;
      wait_edge(8'hFD);
      load_val(16'h9999, 4'b1111, 4'b0000);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_pre got=%b want=1", busy); end
      reset = 1'b1;
      @(negedge clk5);
      total++;
      if (digit !== 8'hFF) begin bad++; $display("FAIL rmid_digit got=%h want=ff", digit); end
      total++;
      if (segment !== 8'hFF) begin bad++; $display("FAIL rmid_seg got=%h want=ff", segment); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      brightness = 4'd15;
      @(negedge clk5);
      reset = 1'b0;
      wait_edge(8'hFE);
      total++;
      if (segment !== 8'h03) begin bad++; $display("FAIL rmid_after_seg got=%h want=03", segment); end
      repeat (70) @(negedge clk5);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rmid_pending_busy got=%b want=0", busy); end
      wait_edge(8'hFE);
      total++;
      if (segment !== 8'h03) begin bad++; $display("FAIL rmid_discard_seg got=%h want=03", segment); end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; dispVal = 16'h0; point = 4'h0; blink = 4'h0;
      lzs_en = 1'b0; brightness = 4'd15;
      repeat (3) @(negedge clk5);
      test_reset;
      test_load;
      test_back_to_back;
      test_load_frame_end;
      test_lzs;
      test_blink;
      test_brightness;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/display_mux_n.md
Name: display_mux_n

Overview:
- Parametrised successor to the 4-digit seven-segment display driver.
- Time-multiplexes up to 8 hex digits onto the board's common-anode display.
- Adds: configurable digit count and refresh rate, double-buffered tear-free updates via a load strobe, per-digit blink, leading-zero suppression, and 16-level PWM brightness.
- Sits between the datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of active digits, 1..8; digits NUM_DIGITS..7 are held off.
- DIV_BITS, 11, refresh slot length is 2**DIV_BITS clk5 cycles; must be >= 4.
- BLINK_FRAMES, 128, number of full scan frames per blink half-period; must be >= 1.

Ports:
- clk5  in  1  system clock (5 MHz on board).
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures dispVal, point and blink.
- dispVal  in  4*NUM_DIGITS  hex value; nibble i drives digit i; digit 0 is rightmost.
- point  in  NUM_DIGITS  decimal point enable per digit, 1 = lit.
- blink  in  NUM_DIGITS  blink enable per digit.
- lzs_en  in  1  leading-zero suppression enable (live, not buffered).
- brightness  in  4  duty level; 15 = full on, 0 = 1/16 on (live, not buffered).
- busy  out  1  high while a captured value is waiting to be applied.
- digit  out  8  digit enables, active low.
- segment  out  8  [7:1] = a..g active low, [0] = dp active low.

Behaviour:
- Reset values: digit = 8'hFF, segment = 8'hFF, busy = 0. Divider, index, blink counter and blink phase = 0. Pending and shadow registers = 0.
- Divider (DIV_BITS wide):
  - Increments every cycle and wraps 2**DIV_BITS-1 -> 0.
  - tick = (divider == all ones), combinational.
- Digit index:
  - Increments on tick and wraps NUM_DIGITS-1 -> 0.
  - frame_end = tick && index == NUM_DIGITS-1.
- Blink counter:
  - Counts frame_end events 0..BLINK_FRAMES-1.
  - On wrap, blink phase toggles.
- Load and double buffering:
  - load with no frame_end: pending <= inputs, busy <= 1. A second load while busy overwrites pending; last write wins.
  - frame_end with busy: shadow <= pending, busy <= 0.
  - load on the same cycle as frame_end: shadow <= new inputs directly, busy <= 0.
  - Display always shows shadow, so a value never changes mid-frame.
- Outputs are registered. digit and segment reflect the index one clock after the index register updates. For slot index i, computed each cycle:
  - off = (blink_shadow[i] && phase == 1) || (divider[DIV_BITS-1 -: 4] > brightness).
  - blank = lzs_en && i != 0 && shadow nibbles i..NUM_DIGITS-1 all zero.
  - digit: 0 at bit i only, unless off (then all ones). Bits >= NUM_DIGITS are always 1.
  - segment[7:1]: font(nibble i), or 7'h7F if blank.
  - segment[0]: ~point_shadow[i]. The point is still shown on a blanked digit.
- Font (a..g, active low):
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F.
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38.
- Reset mid-operation: any pending load is discarded, busy drops, and the display blanks on the next cycle.
- NUM_DIGITS = 1: index is constant 0, and frame_end = tick.

Test Plan (NUM_DIGITS=4, DIV_BITS=4, BLINK_FRAMES=2 unless stated):
- Reset then release, no load:
  - Every digit 0 slot shows segment = 8'h03 (0, dp off), digit = 8'hFE.
  - Digits 1..3 show segment = 8'h03 with lzs_en = 0.
  - Scan order is FE, FD, FB, F7, repeating every 64 cycles.
- load with dispVal=16'h12AF, point=4'b0100, brightness=15:
  - busy goes 1 and stays 1 until the next frame_end, then drops.
  - Digit 0 shows 8'h71 (F). Digit 1 shows 8'h11 (A). Digit 2 shows 8'h24 (2 with dp). Digit 3 shows 8'h9F (1).
- Back-to-back loads 16'h1111 then 16'h2222 within one frame:
  - Only 2222 ever appears on the display; 1111 never does.
- lzs_en=1, dispVal=16'h0050, point=4'b1000:
  - Digit 3 shows 8'hFE (blank with dp lit).
  - Digit 2 shows 8'hFF.
  - Digit 1 shows 8'h49 (5). Digit 0 shows 8'h03 (0, not blanked).
- blink=4'b0001, brightness=15:
  - Digit 0 enable is absent for 2 frames, then present for 2 frames, repeating.
  - Digits 1..3 are unaffected.
- brightness=3, DIV_BITS=4:
  - Each digit enable is low for 4 of every 16 cycles in its slot.
  - Assert reset mid-slot: digit = 8'hFF on the next cycle.
